// File: rtl/fir_mac_filter.sv
// fir_mac_filter: time-multiplexed FIR filter with one signed multiplier shared across all taps and channels.
// Define FIR_SATURATE_EN to clamp the output to the DATA_W signed range; otherwise the result wraps.
module fir_mac_filter #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 57,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W  = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_channel,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_channel,
  output logic signed [DATA_W-1:0] out_sample,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE_TAP  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_hist [CHANNELS][TAPS];
  logic [ADDR_W-1:0]         r_wrPtr [CHANNELS];
  logic signed [COEF_W-1:0]  r_coef [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [CH_W-1:0]           r_chan;
  logic [ADDR_W-1:0]         r_tap;
  logic [ADDR_W-1:0]         r_rdIdx;
  logic                      r_inReady;
  logic                      r_outValid;
  logic [CH_W-1:0]           r_outChannel;
  logic signed [DATA_W-1:0]  r_outSample;
  logic                      r_coefErr;

  logic                      w_chanOk;
  logic                      w_addrOk;
  logic                      w_accept;
  logic                      w_coefWrite;
  logic signed [DATA_W-1:0]  w_histVal;
  logic signed [COEF_W-1:0]  w_coefVal;
  logic signed [PROD_W-1:0]  w_histExt;
  logic signed [PROD_W-1:0]  w_coefExt;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_accNext;
  logic signed [DATA_W-1:0]  w_result;

  assign w_chanOk    = ({1'b0, in_channel} < (CH_W + 1)'(CHANNELS));
  assign w_addrOk    = ({1'b0, coef_addr} < (ADDR_W + 1)'(TAPS));
  assign w_accept    = (r_state == S_IDLE) && in_valid && w_chanOk;
  assign w_coefWrite = (r_state == S_IDLE) && coef_we && w_addrOk;

  // One product per MAC cycle: tap r_tap against the sample r_tap steps back from the newest.
  assign w_histVal = r_hist[r_chan][r_rdIdx];
  assign w_coefVal = r_coef[r_tap];
  assign w_histExt = {{COEF_W{w_histVal[DATA_W-1]}}, w_histVal};
  assign w_coefExt = {{DATA_W{w_coefVal[COEF_W-1]}}, w_coefVal};
  assign w_prod    = w_histExt * w_coefExt;
  assign w_accNext = r_acc + {{ADDR_W{w_prod[PROD_W-1]}}, w_prod};

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_OUT = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_OUT = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = w_accNext >>> SHIFT;

  always_comb begin
    w_result = w_shifted[DATA_W-1:0];
    if (w_shifted > MAX_OUT) begin
      w_result = MAX_OUT[DATA_W-1:0];
    end else if (w_shifted < MIN_OUT) begin
      w_result = MIN_OUT[DATA_W-1:0];
    end
  end
`else
  // Low DATA_W bits of acc >>> SHIFT; sign bits above are dropped and the value wraps.
  assign w_result = w_accNext[SHIFT +: DATA_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_inReady    <= 1'b1;
      r_outValid   <= 1'b0;
      r_outChannel <= '0;
      r_outSample  <= '0;
      r_coefErr    <= 1'b0;
      r_acc        <= '0;
      r_chan       <= '0;
      r_tap        <= '0;
      r_rdIdx      <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_wrPtr[c] <= '0;
        for (int k = 0; k < TAPS; k++) begin
          r_hist[c][k] <= '0;
        end
      end
      for (int k = 0; k < TAPS; k++) begin
        r_coef[k] <= '0;
      end
    end else begin
      r_outValid <= 1'b0;
      r_coefErr  <= coef_we && !w_coefWrite;
      if (w_coefWrite) begin
        r_coef[coef_addr] <= coef_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hist[in_channel][r_wrPtr[in_channel]] <= in_sample;
            r_chan    <= in_channel;
            r_rdIdx   <= r_wrPtr[in_channel];
            r_tap     <= '0;
            r_acc     <= '0;
            r_inReady <= 1'b0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc   <= w_accNext;
          r_tap   <= r_tap + ONE_TAP;
          r_rdIdx <= (r_rdIdx == '0) ? LAST_TAP : r_rdIdx - ONE_TAP;
          // The final product is folded in here so out_valid lands in the OUT cycle.
          if (r_tap == LAST_TAP) begin
            r_outSample     <= w_result;
            r_outChannel    <= r_chan;
            r_outValid      <= 1'b1;
            r_wrPtr[r_chan] <= (r_wrPtr[r_chan] == LAST_TAP) ? '0 : r_wrPtr[r_chan] + ONE_TAP;
            r_state         <= S_OUT;
          end
        end
        S_OUT: begin
          r_inReady <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_inReady <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign out_channel = r_outChannel;
  assign out_sample  = r_outSample;
  assign coef_err    = r_coefErr;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter: directed self-checking bench for fir_mac_filter at default parameters.
// Expected values are hand-derived constants plus a shift-register convolution model.
`timescale 1ns/1ps
module tb_fir_mac_filter;

  localparam int TAPS = 57;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [0:0]         in_channel = '0;
  logic signed [15:0] in_sample = '0;
  logic               out_valid;
  logic [0:0]         out_channel;
  logic signed [15:0] out_sample;
  logic               coef_we = 1'b0;
  logic [5:0]         coef_addr = '0;
  logic signed [7:0]  coef_data = '0;
  logic               coef_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lastAccept = 0;
  int prevAccept = 0;
  int histM [2][TAPS];
  int coefM [TAPS];
  logic signed [31:0] e;

  fir_mac_filter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_channel  (in_channel),
    .in_sample   (in_sample),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .out_sample  (out_sample),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_err    (coef_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed, input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < TAPS; k++) histM[c][k] = 0;
    for (int k = 0; k < TAPS; k++) coefM[k] = 0;
  endtask

  // Newest sample sits at index 0 of the model history; y = sum coef[k] * x[n-k].
  function automatic logic signed [31:0] modelPush(input int ch, input int s);
    longint acc;
    longint sh;
    for (int k = TAPS - 1; k > 0; k--) histM[ch][k] = histM[ch][k-1];
    histM[ch][0] = s;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(coefM[k]) * longint'(histM[ch][k]);
    sh = acc >>> 8;
`ifdef FIR_SATURATE_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
    return sh[31:0];
`else
    begin
      logic signed [15:0] lo;
      lo = sh[15:0];
      return lo;
    end
`endif
  endfunction

  task automatic writeCoef(input int addr, input int data, input bit expectOk);
    coef_we   = 1'b1;
    coef_addr = addr[5:0];
    coef_data = data[7:0];
    tick;
    coef_we = 1'b0;
    if (expectOk) coefM[addr] = data;
    checkOutput("coef_err", coef_err, expectOk ? 0 : 1);
  endtask

  task automatic applyStimulus(input int ch, input int s, input bit holdValid, output logic signed [31:0] expVal);
    int budget;
    in_channel = ch[0:0];
    in_sample  = s[15:0];
    in_valid   = 1'b1;
    budget = 0;
    while (!in_ready && budget < 200) begin
      tick;
      budget++;
    end
    checkOutput("accept_ready", in_ready, 1);
    tick;
    lastAccept = cyc;
    if (!holdValid) in_valid = 1'b0;
    expVal = modelPush(ch, s);
  endtask

  task automatic waitOutput(input string tag, input logic signed [31:0] expVal, input int expCh);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick;
      n++;
    end
    checkOutput({tag, "_latency"}, cyc - lastAccept + 1, TAPS + 1);
    checkOutput({tag, "_sample"}, out_sample, expVal);
    checkOutput({tag, "_chan"}, out_channel, expCh);
    checkOutput({tag, "_busy"}, in_ready, 0);
    tick;
    checkOutput({tag, "_pulse"}, out_valid, 0);
    checkOutput({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    clearModel();
    repeat (3) tick;
    rst = 1'b0;
    tick;
    $display("[TB] reset values");
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sample", out_sample, 0);
    checkOutput("rst_out_channel", out_channel, 0);
    checkOutput("rst_coef_err", coef_err, 0);

    $display("[TB] impulse response");
    for (int k = 0; k < TAPS; k++) writeCoef(k, k - 28, 1'b1);
    for (int i = 0; i < TAPS; i++) begin
      int hand;
      applyStimulus(0, (i == 0) ? 1000 : 0, 1'b0, e);
      hand = (1000 * (i - 28)) >>> 8;
      waitOutput("impulse", hand, 0);
    end

    $display("[TB] channel isolation");
    for (int k = 0; k < TAPS; k++) writeCoef(k, (k < 2) ? 64 : 0, 1'b1);
    applyStimulus(0, 400, 1'b0, e);
    waitOutput("iso_ch0_a", 100, 0);
    applyStimulus(1, -800, 1'b0, e);
    waitOutput("iso_ch1_a", -200, 1);
    applyStimulus(0, 400, 1'b0, e);
    waitOutput("iso_ch0_b", 200, 0);
    applyStimulus(1, -800, 1'b0, e);
    waitOutput("iso_ch1_b", -400, 1);

    $display("[TB] coefficient write while busy");
    applyStimulus(1, 0, 1'b0, e);
    writeCoef(0, 5, 1'b0);
    tick;
    checkOutput("busy_err_clear", coef_err, 0);
    waitOutput("busy", -200, 1);
    applyStimulus(1, 256, 1'b0, e);
    waitOutput("readback", 64, 1);
    writeCoef(60, 7, 1'b0);
    tick;
    checkOutput("addr_err_clear", coef_err, 0);

    $display("[TB] coefficient write in accept cycle");
    checkOutput("same_ready", in_ready, 1);
    coef_we    = 1'b1;
    coef_addr  = 6'd0;
    coef_data  = 8'sd100;
    in_channel = 1'b0;
    in_sample  = 16'sd512;
    in_valid   = 1'b1;
    tick;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    lastAccept = cyc;
    coefM[0] = 100;
    e = modelPush(0, 512);
    checkOutput("same_coef_err", coef_err, 0);
    waitOutput("same_cycle", 300, 0);

    $display("[TB] saturation");
    for (int k = 0; k < TAPS; k++) writeCoef(k, 127, 1'b1);
    for (int i = 0; i < TAPS - 1; i++) begin
      applyStimulus(1, 32767, 1'b0, e);
      waitOutput("sat_ramp", e, 1);
    end
    applyStimulus(1, 32767, 1'b0, e);
`ifdef FIR_SATURATE_EN
    waitOutput("sat_last", 32767, 1);
`else
    waitOutput("sat_last", 9059, 1);
`endif

    $display("[TB] reset mid-MAC");
    applyStimulus(0, 1000, 1'b0, e);
    repeat (10) tick;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_sample", out_sample, 0);
    checkOutput("mid_rst_out_channel", out_channel, 0);
    checkOutput("mid_rst_coef_err", coef_err, 0);
    tick;
    rst = 1'b0;
    clearModel();
    begin
      int seen;
      seen = 0;
      repeat (70) begin
        tick;
        if (out_valid) seen++;
      end
      checkOutput("mid_rst_no_output", seen, 0);
    end
    for (int k = 0; k < TAPS; k++) writeCoef(k, k - 28, 1'b1);
    applyStimulus(0, 1000, 1'b0, e);
    waitOutput("post_rst_a", -110, 0);
    applyStimulus(0, 0, 1'b0, e);
    waitOutput("post_rst_b", -106, 0);

    $display("[TB] back-to-back across history wrap");
    for (int i = 0; i < 120; i++) begin
      applyStimulus(0, ((i * 7919) % 6001) - 3000, 1'b1, e);
      if (i > 0) checkOutput("b2b_gap", lastAccept - prevAccept, TAPS + 2);
      prevAccept = lastAccept;
      waitOutput("b2b", e, 0);
    end
    in_valid = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Time-multiplexed, runtime-programmable FIR filter: the parametrised successor to the fixed-coefficient systolic filter in the audio path. One signed multiplier is shared across all taps and across `CHANNELS` interleaved audio channels, each with its own sample history. Coefficients load through a write port. The block sits between the sample-rate front end and the spectrum/display stages, where `in_valid` takes the place of the old `new_sample` strobe.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `COEF_W`, 8: coefficient width, signed.
- `TAPS`, 57: filter length, ≥2.
- `CHANNELS`, 2: independent channels, ≥1.
- `SHIFT`, 8: arithmetic right shift applied to the accumulator before output.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: block idle and able to accept a sample.
- `in_channel` in max(1,$clog2(CHANNELS)): channel of the offered sample.
- `in_sample` in DATA_W: input sample.
- `out_valid` out 1: one-cycle pulse when the result is valid.
- `out_channel` out max(1,$clog2(CHANNELS)): channel of the result.
- `out_sample` out DATA_W: filtered sample, held until the next `out_valid`.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in $clog2(TAPS): tap index k.
- `coef_data` in COEF_W: coefficient value.
- `coef_err` out 1: one-cycle pulse when a coefficient write is dropped.

## Operation
- Per channel, there is a `TAPS`-entry history ring with a write pointer. A handshake on channel c writes `in_sample` at the pointer. The newest sample is x[n].
- Output: y[n] = Σ_{k=0..TAPS-1} coef[k]·x[n-k]. Coefficient k=0 multiplies the newest sample.
- The accumulator has width ACC_W = DATA_W+COEF_W+$clog2(TAPS). Products are sign-extended to ACC_W and summed exactly, with no intermediate overflow.
- The result is acc >>> SHIFT (arithmetic shift), reduced to DATA_W per the Configuration section.
- State machine:
  - IDLE, `in_ready`=1. On `in_valid` with `in_channel`<CHANNELS, latch the channel, write the sample, clear the accumulator, and go to MAC.
  - If `in_channel`≥CHANNELS, drop the sample, stay in IDLE, and produce no output.
  - MAC: exactly TAPS cycles, one product per cycle, k=0..TAPS-1. Then go to OUT.
  - OUT: register `out_sample` and `out_channel`, pulse `out_valid`, and return to IDLE.
- After the MAC pass, the channel's write pointer advances modulo TAPS. The wrap from TAPS-1 to 0 is seamless. Other channels' histories and pointers are untouched.
- Coefficient writes:
  - `coef_we` in IDLE writes `coef[coef_addr]`. The new value takes effect on the next accepted sample.
  - `coef_we` in MAC or OUT is dropped and `coef_err` pulses on the next cycle.
  - `coef_addr`≥TAPS is dropped and `coef_err` pulses.
  - `coef_we` and a sample accept in the same IDLE cycle: the write completes first, so the accepted sample uses the new coefficient.
- Reset values:
  - State IDLE, `in_ready`=1.
  - `out_valid`=0, `out_sample`=0, `out_channel`=0, `coef_err`=0.
  - All histories, pointers, coefficients and the accumulator are 0.
- Reset asserted mid-MAC: the partial result is discarded and no `out_valid` is produced. The sample written at acceptance is cleared by the reset.

## Timing
- Handshake in cycle T (rising edge with `in_valid`&&`in_ready`):
  - `in_ready`=0 for cycles T+1..T+TAPS+1.
  - `out_valid`=1 in cycle T+TAPS+1 only.
  - `in_ready`=1 again in cycle T+TAPS+2.
- Latency is TAPS+1 cycles from accept to `out_valid`. Maximum throughput is one sample per TAPS+2 cycles, summed across all channels.
- `in_valid` while `in_ready`=0 is not accepted. The source must hold the sample until accepted.
- `coef_err` asserts 1 cycle after the offending `coef_we` and lasts 1 cycle.

## Configuration
- `FIR_SATURATE_EN` defined: if the shifted result exceeds the DATA_W signed range, it clamps to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
- `FIR_SATURATE_EN` undefined: the low DATA_W bits of the shifted result are output and wrap silently. This matches the previous bit-slice behaviour and saves the comparator logic.

## Test plan
All scenarios use the defaults DATA_W=16, COEF_W=8, TAPS=57, CHANNELS=2, SHIFT=8.
- **Impulse response.** Load coef[k]=k-28, then feed 1000 followed by 56 zeros on ch0. The outputs must be (1000·(k-28))>>>8 for k=0..56, each 58 cycles after its accept.
- **Channel isolation.** Load coef[0]=coef[1]=64, all others 0. Interleave ch0 samples 400, 400 with ch1 samples -800, -800. The second outputs must be ch0=200 and ch1=-400, with `out_channel` correct.
- **Saturation.** Set all coef=127 and feed 57 samples of 32767.
  - With `FIR_SATURATE_EN`: the last output is 32767.
  - Without it: the last output equals bits [15:0] of (57·127·32767)>>>8.
- **Coefficient write while busy.** Write coef[0]=5 during MAC: `coef_err` pulses and a readback impulse shows coef[0] unchanged. Write coef_addr=60 in IDLE: `coef_err` pulses.
- **Reset mid-operation.** Assert `rst` 10 cycles into MAC. No `out_valid` is produced, all outputs are 0, and `in_ready`=1 immediately. The next impulse yields a zero-history response.
- **Back-to-back and wrap.** Drive `in_valid` high continuously for 120 samples on ch0. Accepts must be exactly 59 cycles apart, and the outputs must match the reference model across the history wrap.
